// File: rtl/med_rank_if.sv
// Request/result bundle between the median-rank selector and its controller.
// The controller side drives the samples, rank and start; the selector returns status and result.
interface med_rank_if #(
  parameter int WIDTH = 16,
  parameter int NUM   = 5
);
  localparam int RW = (NUM > 1) ? $clog2(NUM) : 1;

  logic                   medtop_med_start;
  logic [RW-1:0]          medtop_med_rank;
  logic [NUM*WIDTH-1:0]   medregs_med_reg_data;
  logic                   med_medtop_busy;
  logic                   med_medtop_finish;
  logic [WIDTH-1:0]       med_medtop_data;
  logic                   med_medtop_err;

  modport master (
    output medtop_med_start,
    output medtop_med_rank,
    output medregs_med_reg_data,
    input  med_medtop_busy,
    input  med_medtop_finish,
    input  med_medtop_data,
    input  med_medtop_err
  );

  modport slave (
    input  medtop_med_start,
    input  medtop_med_rank,
    input  medregs_med_reg_data,
    output med_medtop_busy,
    output med_medtop_finish,
    output med_medtop_data,
    output med_medtop_err
  );
endinterface

// File: rtl/med_rank.sv
// Rank selector: loads NUM samples, sorts them by odd-even transposition
// (one phase per cycle), then returns the sample at the requested rank.
module med_rank #(
  parameter int WIDTH  = 16,
  parameter int NUM    = 5,
  parameter int SIGNED = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  med_rank_if.slave bus
);
  localparam int RW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK  = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] SIGN_FLIP = (SIGNED != 0) ? MSB_MASK : '0;

  typedef enum logic [2:0] {IDLE, LOAD, SORT, SEL, FIN} state_t;

  state_t           state_reg, state_next;
  logic [RW-1:0]    phase_reg;
  logic [RW-1:0]    rank_reg;
  logic [WIDTH-1:0] res_reg;
  logic             err_reg;
  logic [WIDTH-1:0] arr_reg    [NUM];
  logic [WIDTH-1:0] sorted_next[NUM];
  logic [NUM-2:0]   swap;
  logic             last_phase;
  logic             rank_oor;

  // Flipping the MSB maps two's-complement order onto unsigned order.
  function automatic logic [WIDTH-1:0] order_key(input logic [WIDTH-1:0] v);
    return v ^ SIGN_FLIP;
  endfunction

  assign last_phase = (phase_reg == RW'(NUM - 1));
  assign rank_oor   = ({1'b0, rank_reg} >= (RW + 1)'(NUM));

  // A pair (gi, gi+1) is active when its left index has the phase's parity.
  generate
    for (genvar gi = 0; gi < NUM - 1; gi++) begin : g_pair
      localparam logic PAIR_ODD = ((gi % 2) == 1);
      assign swap[gi] = (phase_reg[0] == PAIR_ODD) &&
                        (order_key(arr_reg[gi]) > order_key(arr_reg[gi+1]));
    end

    for (genvar gi = 0; gi < NUM; gi++) begin : g_elem
      if (gi == 0) begin : g_first
        assign sorted_next[gi] = swap[gi] ? arr_reg[gi+1] : arr_reg[gi];
      end else if (gi == NUM - 1) begin : g_last
        assign sorted_next[gi] = swap[gi-1] ? arr_reg[gi-1] : arr_reg[gi];
      end else begin : g_mid
        assign sorted_next[gi] = swap[gi]   ? arr_reg[gi+1] :
                                 swap[gi-1] ? arr_reg[gi-1] : arr_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.medtop_med_start) state_next = LOAD;
      LOAD:    state_next = SORT;
      SORT:    if (last_phase) state_next = SEL;
      SEL:     state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.med_medtop_busy   = (state_reg != IDLE);
    bus.med_medtop_finish = (state_reg == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= '0;
      rank_reg  <= '0;
      res_reg   <= '0;
      err_reg   <= 1'b0;
      for (int i = 0; i < NUM; i++) arr_reg[i] <= '0;
    end else begin
      case (state_reg)
        LOAD: begin
          for (int i = 0; i < NUM; i++)
            arr_reg[i] <= bus.medregs_med_reg_data[i*WIDTH +: WIDTH];
          rank_reg  <= bus.medtop_med_rank;
          phase_reg <= '0;
        end
        SORT: begin
          for (int i = 0; i < NUM; i++) arr_reg[i] <= sorted_next[i];
          phase_reg <= last_phase ? '0 : phase_reg + RW'(1);
        end
        SEL: begin
          // Out-of-range ranks saturate to the largest sample and flag an error.
          if (rank_oor) begin
            res_reg <= arr_reg[NUM-1];
            err_reg <= 1'b1;
          end else begin
            res_reg <= arr_reg[rank_reg];
            err_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.med_medtop_data = res_reg;
  assign bus.med_medtop_err  = err_reg;
endmodule

// File: tb/tb_med_rank.sv
// Bench for med_rank: directed scenarios plus random runs checked against a
// sort-and-pick reference model, on unsigned/signed NUM=5 and unsigned NUM=3 instances.
module tb_med_rank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  med_rank_if #(.WIDTH(16), .NUM(5)) if_u ();
  med_rank_if #(.WIDTH(16), .NUM(5)) if_s ();
  med_rank_if #(.WIDTH(16), .NUM(3)) if_3 ();

  // The signed instance sees exactly the same requests as the unsigned one.
  assign if_s.medtop_med_start     = if_u.medtop_med_start;
  assign if_s.medtop_med_rank      = if_u.medtop_med_rank;
  assign if_s.medregs_med_reg_data = if_u.medregs_med_reg_data;

  med_rank #(.WIDTH(16), .NUM(5), .SIGNED(0)) dut_u (.clk(clk), .rst_n(rst_n), .bus(if_u.slave));
  med_rank #(.WIDTH(16), .NUM(5), .SIGNED(1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s.slave));
  med_rank #(.WIDTH(16), .NUM(3), .SIGNED(0)) dut_3 (.clk(clk), .rst_n(rst_n), .bus(if_3.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] pack5(input logic [15:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  // Reference: interpret samples as integers, sort ascending, pick by rank.
  function automatic logic [16:0] ref_sel(input logic [79:0] bus, input int num,
                                          input int rank, input bit sgn);
    int k[5];
    int t;
    int idx;
    logic [15:0] raw;
    for (int i = 0; i < num; i++) begin
      raw  = bus[i*16 +: 16];
      k[i] = sgn ? int'($signed(raw)) : int'(raw);
    end
    for (int i = 1; i < num; i++) begin
      for (int j = i; j > 0 && k[j-1] > k[j]; j--) begin
        t = k[j]; k[j] = k[j-1]; k[j-1] = t;
      end
    end
    idx = (rank >= num) ? num - 1 : rank;
    t = k[idx];
    return {(rank >= num) ? 1'b1 : 1'b0, t[15:0]};
  endfunction

  // One NUM=5 run starting at C0; optional stray start pulses in cycles xa/xb.
  task automatic run5(input string tag, input logic [79:0] bus, input logic [2:0] rank,
                      input int xa, input int xb);
    logic [16:0] eu, es;
    eu = ref_sel(bus, 5, int'(rank), 1'b0);
    es = ref_sel(bus, 5, int'(rank), 1'b1);
    @(negedge clk);
    check({tag, "_idle"}, if_u.med_medtop_busy, 1'b0);
    if_u.medregs_med_reg_data = bus;
    if_u.medtop_med_rank      = rank;
    if_u.medtop_med_start     = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if_u.medtop_med_start = (cyc == xa) || (cyc == xb);
      if (cyc == 1) check({tag, "_busy_c1"}, if_u.med_medtop_busy, 1'b1);
      if (cyc <= 8) check($sformatf("%s_fin_c%0d", tag, cyc), if_u.med_medtop_finish, cyc == 8);
      if (cyc == 8) begin
        check({tag, "_fin_s"},  if_s.med_medtop_finish, 1'b1);
        check({tag, "_data_u"}, if_u.med_medtop_data, eu[15:0]);
        check({tag, "_err_u"},  if_u.med_medtop_err, eu[16]);
        check({tag, "_data_s"}, if_s.med_medtop_data, es[15:0]);
        check({tag, "_err_s"},  if_s.med_medtop_err, es[16]);
      end
      if (cyc == 10) begin
        check({tag, "_fin_c10"},  if_u.med_medtop_finish, 1'b0);
        check({tag, "_busy_c10"}, if_u.med_medtop_busy, 1'b0);
        check({tag, "_hold_u"},   if_u.med_medtop_data, eu[15:0]);
      end
    end
    $display("run %s rank=%0d data_u=%0h err_u=%0b data_s=%0h err_s=%0b", tag, rank,
             if_u.med_medtop_data, if_u.med_medtop_err, if_s.med_medtop_data, if_s.med_medtop_err);
  endtask

  task automatic run3(input string tag, input logic [47:0] bus, input logic [1:0] rank);
    logic [16:0] e3;
    e3 = ref_sel({32'd0, bus}, 3, int'(rank), 1'b0);
    @(negedge clk);
    if_3.medregs_med_reg_data = bus;
    if_3.medtop_med_rank      = rank;
    if_3.medtop_med_start     = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if_3.medtop_med_start = 1'b0;
      if (cyc <= 6) check($sformatf("%s_fin_c%0d", tag, cyc), if_3.med_medtop_finish, cyc == 6);
      if (cyc == 6) begin
        check({tag, "_data"}, if_3.med_medtop_data, e3[15:0]);
        check({tag, "_err"},  if_3.med_medtop_err, e3[16]);
      end
    end
    $display("run %s rank=%0d data=%0h err=%0b", tag, rank, if_3.med_medtop_data, if_3.med_medtop_err);
  endtask

  initial begin
    logic [79:0] base, alt, bus;
    logic [16:0] ea, eb;
    int          fin_cnt;

    if_u.medtop_med_start = 1'b0;
    if_u.medtop_med_rank = '0;
    if_u.medregs_med_reg_data = '0;
    if_3.medtop_med_start = 1'b0;
    if_3.medtop_med_rank = '0;
    if_3.medregs_med_reg_data = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", if_u.med_medtop_busy, 1'b0);
    check("rst_fin",  if_u.med_medtop_finish, 1'b0);
    check("rst_data", if_u.med_medtop_data, 16'h0);
    check("rst_err",  if_u.med_medtop_err, 1'b0);
    check("rst_data3", if_3.med_medtop_data, 16'h0);
    rst_n = 1'b1;

    base = pack5(16'd9, 16'd3, 16'd7, 16'd1, 16'd5);
    run5("basic", base, 3'd2, 0, 0);
    check("basic_lit", if_u.med_medtop_data, 16'd5);
    run5("rank0", base, 3'd0, 0, 0);
    check("rank0_lit", if_u.med_medtop_data, 16'd1);
    run5("rank4", base, 3'd4, 0, 0);
    check("rank4_lit", if_u.med_medtop_data, 16'd9);
    run5("oor", base, 3'd7, 0, 0);
    check("oor_lit_data", if_u.med_medtop_data, 16'd9);
    check("oor_lit_err",  if_u.med_medtop_err, 1'b1);

    run5("signed", pack5(16'hFFFD, 16'h0002, 16'h0000, 16'hFFF8, 16'h0005), 3'd2, 0, 0);
    check("signed_lit_s", if_s.med_medtop_data, 16'h0000);
    check("signed_lit_u", if_u.med_medtop_data, 16'h0005);

    run5("stray", base, 3'd2, 3, 8);

    // Start held high: back-to-back runs, bus changed before the second LOAD.
    alt = pack5(16'd40, 16'd10, 16'd30, 16'd20, 16'd50);
    ea = ref_sel(base, 5, 3, 1'b0);
    eb = ref_sel(alt, 5, 3, 1'b0);
    @(negedge clk);
    if_u.medregs_med_reg_data = base;
    if_u.medtop_med_rank = 3'd3;
    if_u.medtop_med_start = 1'b1;
    for (int cyc = 1; cyc <= 27; cyc++) begin
      @(negedge clk);
      check($sformatf("held_fin_c%0d", cyc), if_u.med_medtop_finish,
            (cyc == 8) || (cyc == 17) || (cyc == 26));
      if (cyc == 8)  check("held_data1", if_u.med_medtop_data, ea[15:0]);
      if (cyc == 17) check("held_data2", if_u.med_medtop_data, eb[15:0]);
      if (cyc == 26) check("held_data3", if_u.med_medtop_data, eb[15:0]);
      if (cyc == 9)  if_u.medregs_med_reg_data = alt;
      if (cyc == 27) if_u.medtop_med_start = 1'b0;
    end
    $display("run held finishes at C8/C17/C26 data=%0h", if_u.med_medtop_data);
    repeat (2) @(negedge clk);

    run3("num3", {16'd6, 16'd8, 16'd4}, 2'd1);
    check("num3_lit", if_3.med_medtop_data, 16'd6);
    run3("num3_oor", {16'd6, 16'd8, 16'd4}, 2'd3);

    // Reset in the middle of a run.
    @(negedge clk);
    if_u.medregs_med_reg_data = base;
    if_u.medtop_med_rank = 3'd2;
    if_u.medtop_med_start = 1'b1;
    @(negedge clk);
    if_u.medtop_med_start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", if_u.med_medtop_busy, 1'b0);
    check("mid_rst_fin",  if_u.med_medtop_finish, 1'b0);
    check("mid_rst_data", if_u.med_medtop_data, 16'h0);
    check("mid_rst_err",  if_u.med_medtop_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    fin_cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (if_u.med_medtop_finish) fin_cnt++;
    end
    check("post_rst_no_fin", fin_cnt, 0);
    check("post_rst_idle", if_u.med_medtop_busy, 1'b0);
    $display("run reset_mid finishes_after_release=%0d", fin_cnt);

    run5("dups", pack5(16'd5, 16'd5, 16'd2, 16'd5, 16'd2), 3'd2, 0, 0);
    check("dups_lit", if_u.med_medtop_data, 16'd5);

    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 5; i++)
        bus[i*16 +: 16] = (n % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 3));
      run5($sformatf("rnd%0d", n), bus, 3'($urandom_range(0, 7)), 0, 0);
    end
    for (int n = 0; n < 6; n++) begin
      run3($sformatf("rnd3_%0d", n), {16'($urandom), 16'($urandom), 16'($urandom)},
           2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/med_rank.md
MED_RANK -- requirements
Module: med_rank

Interface
Parameters:
REQ-001 SHALL have parameter WIDTH, default 16, sample bit width (1..32).
REQ-002 SHALL have parameter NUM, default 5, number of samples (2..16).
REQ-003 SHALL have parameter SIGNED, default 0; 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 SHALL define RW = ceil(log2(NUM)), minimum 1, as the rank width.

Ports:
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port medtop_med_start, input, 1, request pulse or level.
REQ-008 SHALL have port medtop_med_rank, input, RW, requested rank; 0 = smallest.
REQ-009 SHALL have port medregs_med_reg_data, input, NUM*WIDTH, flat sample bus; sample i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port med_medtop_busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port med_medtop_finish, output, 1, one-cycle completion strobe.
REQ-012 SHALL have port med_medtop_data, output, WIDTH, selected sample value.
REQ-013 SHALL have port med_medtop_err, output, 1, rank out of range on the last run.

Function
REQ-014 SHALL implement states IDLE, LOAD, SORT, SEL, FIN.
REQ-015 State transitions SHALL be:
- IDLE -> LOAD when start=1, else stay in IDLE.
- LOAD -> SORT.
- SORT -> SEL after NUM SORT cycles.
- SEL -> FIN.
- FIN -> IDLE, unconditionally.
REQ-016 Start SHALL be sampled only in IDLE; start in any other state (including FIN) SHALL be ignored, with no queuing.
REQ-017 The LOAD cycle SHALL capture all NUM samples into an internal array a[0..NUM-1] and medtop_med_rank into rank_r; inputs SHALL be don't-care in all other cycles.
REQ-018 SORT SHALL run odd-even transposition using a phase counter p = 0..NUM-1:
- Even p: compare-swap pairs (0,1), (2,3), ...
- Odd p: compare-swap pairs (1,2), (3,4), ...
- All pairs of a phase update in the same cycle.
REQ-019 A compare-swap SHALL exchange a[j] and a[j+1] only if a[j] > a[j+1] under the SIGNED compare rule; equal values SHALL NOT be swapped.
REQ-020 After NUM phases, a[] SHALL be in ascending order for any input.
REQ-021 If rank_r >= NUM, SEL SHALL load result register res_r with a[NUM-1] and set err_r=1.
REQ-022 If rank_r < NUM, SEL SHALL load res_r with a[rank_r] and set err_r=0.
REQ-023 med_medtop_finish SHALL be 1 exactly during FIN.
REQ-024 med_medtop_data SHALL equal res_r, and med_medtop_err SHALL equal err_r; both update only in SEL and hold until the next SEL.
REQ-025 Timing SHALL be as follows, with C0 the IDLE cycle sampling start=1:
- C1: LOAD.
- C2..C(NUM+1): SORT.
- C(NUM+2): SEL.
- C(NUM+3): FIN.
- Latency from start to finish = NUM+3 cycles.
REQ-026 With start held high continuously, runs SHALL be back-to-back with one finish every NUM+4 cycles, each run re-sampling the data bus and rank in its own LOAD cycle.
REQ-027 For NUM=3, rank=1 SHALL return the median of the three samples.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, p=0, a[]=0, rank_r=0, res_r=0, and err_r=0, giving busy=0, finish=0, data=0, and err=0.
REQ-029 Reset asserted mid-run SHALL abort the run with no finish pulse, and no finish SHALL occur after release until a new start is sampled in IDLE.

Verification
REQ-030 The bench SHALL cover the following scenarios, with NUM=5, WIDTH=16 unless noted:
- Basic median: samples 9,3,7,1,5, rank 2, start pulse at C0 -> busy from C1; finish=1 only at C8; data=5; err=0; data held at 5 after C8.
- Extreme ranks: same samples, rank 0 -> data=1; rank 4 -> data=9.
- Out-of-range rank: same samples, rank 7 -> data=9, err=1 at C8.
- Signed compare: samples 0xFFFD,0x0002,0x0000,0xFFF8,0x0005, rank 2 -> SIGNED=1 gives data=0x0000; SIGNED=0 gives data=0x0005.
- Start handling: extra start pulses at C3 and at C8 (FIN) -> ignored, single finish. Start held high -> finish at C8, C17, C26. NUM=3 with samples 4,8,6, rank 1 -> data=6.
- Reset mid-run: rst_n low during C4 -> all outputs 0 immediately; after release with start=0 for 20 cycles -> no finish; duplicates 5,5,2,5,2, rank 2 -> data=5.
